// File: rtl/pcm_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pcm_pkg
// Description : Shared widths, codeword/sample types and deserializer states
//               for the receive-side PCM log-to-linear expander.
// Revision    : 1.0  initial release
// ============================================================================
package pcm_pkg;

  localparam int LOG_W  = 8;
  localparam int LIN_W  = 13;
  localparam int SEG_W  = 3;
  localparam int MANT_W = 4;

  // XOR pattern applied by an A-law line that inverts the even bits.
  localparam logic [LOG_W-1:0] EVEN_INV_MASK = 8'h55;

  // Compressed codeword as it arrives on the line.
  typedef struct packed {
    logic              sign;
    logic [SEG_W-1:0]  seg;
    logic [MANT_W-1:0] mant;
  } pcm_code_t;

  // Sign-magnitude linear sample.
  typedef struct packed {
    logic             sign;
    logic [LIN_W-2:0] mag;
  } pcm_lin_t;

  // Deserializer states.
  typedef enum logic [0:0] {
    ST_HUNT  = 1'b0,
    ST_SHIFT = 1'b1
  } deser_state_t;

endpackage : pcm_pkg
`default_nettype wire

// File: rtl/pcm_log2lin_expand.sv
`default_nettype none
// ============================================================================
// Module      : pcm_log2lin_expand
// Description : Purely combinational expansion of an 8-bit segmented log
//               codeword into a 13-bit sign-magnitude linear sample.
// Revision    : 1.0  initial release
// ============================================================================
module pcm_log2lin_expand
  import pcm_pkg::*;
(
  input  logic [LOG_W-1:0] code_i,
  output logic [LIN_W-1:0] lin_o
);

  pcm_code_t code;
  pcm_lin_t  lin;

  // Segment 0 is linear; higher segments restore the implicit leading one
  // and add a half-step bit so the output sits mid-interval.
  always_comb begin
    code     = pcm_code_t'(code_i);
    lin.sign = code.sign;
    lin.mag  = '0;
    if (code.seg == '0) begin
      lin.mag = {7'b0, code.mant, 1'b1};
    end else begin
      lin.mag = (12'd1 << ({1'b0, code.seg} + 4'd4))
              | ({8'b0, code.mant} << code.seg)
              | (12'd1 << (code.seg - 3'd1));
    end
    lin_o = lin;
  end

endmodule : pcm_log2lin_expand
`default_nettype wire

// File: rtl/pcm_log2lin_rx.sv
`default_nettype none
// ============================================================================
// Module      : pcm_log2lin_rx
// Description : Receive-side PCM expander. Deserializes framed 8-bit log
//               codewords (MSB first), expands them to 13-bit linear PCM and
//               queues the samples in a small valid/ready FIFO.
//               Build option: PCM_EVEN_BIT_INV_EN undoes A-law even-bit
//               inversion (XOR 8'h55) before expansion.
// Revision    : 1.0  initial release
// ============================================================================
module pcm_log2lin_rx #(
  parameter int FIFO_DEPTH = 4,
  parameter int LIN_W      = 13
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             bit_in,
  input  logic             bit_valid,
  input  logic             frame_sync,
  output logic [LIN_W-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             overrun,
  output logic             sync_err
);

  import pcm_pkg::*;

  localparam int            AW      = $clog2(FIFO_DEPTH);
  localparam logic [AW:0]   PTR_ONE = (AW+1)'(1);

  // --------------------------------------------------------------------------
  // Deserializer
  // --------------------------------------------------------------------------
  deser_state_t     state_q, state_d;
  logic [2:0]       cnt_q, cnt_d;
  logic [LOG_W-1:0] code_q, code_d;
  logic             word_done_q, word_done_d;
  logic             sync_err_q, sync_err_d;

  // Deserializer state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_HUNT;
      cnt_q       <= '0;
      code_q      <= '0;
      word_done_q <= 1'b0;
      sync_err_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      code_q      <= code_d;
      word_done_q <= word_done_d;
      sync_err_q  <= sync_err_d;
    end
  end

  // Next-state logic: frame_sync always restarts a word at the MSB; if it
  // lands mid-word the partial code is abandoned and flagged.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    code_d      = code_q;
    word_done_d = 1'b0;
    sync_err_d  = 1'b0;
    if (bit_valid) begin
      if (frame_sync) begin
        sync_err_d = (state_q == ST_SHIFT);
        code_d     = {bit_in, {(LOG_W-1){1'b0}}};
        cnt_d      = 3'd6;
        state_d    = ST_SHIFT;
      end else if (state_q == ST_SHIFT) begin
        code_d[cnt_q] = bit_in;
        if (cnt_q == 3'd0) begin
          word_done_d = 1'b1;
          state_d     = ST_HUNT;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // Expansion; code_q still holds the finished word during the word_done
  // cycle even if the next MSB is being loaded on the same edge.
  // --------------------------------------------------------------------------
  logic [LOG_W-1:0] code_exp;
  logic [LIN_W-1:0] lin_sample;

`ifdef PCM_EVEN_BIT_INV_EN
  assign code_exp = code_q ^ EVEN_INV_MASK;
`else
  assign code_exp = code_q;
`endif

  pcm_log2lin_expand u_expand (
    .code_i (code_exp),
    .lin_o  (lin_sample)
  );

  // --------------------------------------------------------------------------
  // Output FIFO
  // --------------------------------------------------------------------------
  logic [LIN_W-1:0] mem_q [FIFO_DEPTH];
  logic [AW:0]      wr_ptr_q, rd_ptr_q;
  logic             overrun_q;
  logic             fifo_empty, fifo_full;
  logic             fifo_pop, fifo_push, fifo_drop;

  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                      (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign fifo_pop   = !fifo_empty && out_ready;
  // A pop on the same edge frees the slot, so a full FIFO can still accept.
  assign fifo_push  = word_done_q && (!fifo_full || fifo_pop);
  assign fifo_drop  = word_done_q && fifo_full && !fifo_pop;

  // FIFO pointers and sticky overrun flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      overrun_q <= 1'b0;
    end else begin
      if (fifo_push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
      if (fifo_pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
      if (fifo_drop) overrun_q <= 1'b1;
    end
  end

  // Sample storage; stale entries are never visible past the pointers.
  always_ff @(posedge clk) begin
    if (fifo_push) mem_q[wr_ptr_q[AW-1:0]] <= lin_sample;
  end

  assign out_valid = !fifo_empty;
  assign out_data  = fifo_empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];
  assign overrun   = overrun_q;
  assign sync_err  = sync_err_q;

endmodule : pcm_log2lin_rx
`default_nettype wire

// File: tb/tb_pcm_log2lin_rx.sv
`default_nettype none
// ============================================================================
// Module      : tb_pcm_log2lin_rx
// Description : Self-checking bench for pcm_log2lin_rx. Random and directed
//               serial codewords are compared against an arithmetic model of
//               the companding law through an expected-sample queue.
// Revision    : 1.0  initial release
// ============================================================================
module tb_pcm_log2lin_rx;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        bit_in;
  logic        bit_valid;
  logic        frame_sync;
  logic [12:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic        overrun;
  logic        sync_err;

  always #5 clk = ~clk;

  pcm_log2lin_rx #(.FIFO_DEPTH(DEPTH), .LIN_W(13)) dut (
    .clk        (clk),
    .rst        (rst),
    .bit_in     (bit_in),
    .bit_valid  (bit_valid),
    .frame_sync (frame_sync),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .overrun    (overrun),
    .sync_err   (sync_err)
  );

  // Stand-alone expander for the exhaustive code sweep.
  logic [7:0]  sw_code;
  logic [12:0] sw_lin;
  pcm_log2lin_expand u_ref_exp (.code_i(sw_code), .lin_o(sw_lin));

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
    end
  endtask

  // Companding law from first principles: segment 0 steps by 2 with a +1
  // offset; segment s spans [2^(s+4), 2^(s+5)) in steps of 2^s, mid-step.
  function automatic logic [12:0] lin_ref(input logic [7:0] c_in, input bit inv);
    logic [7:0] c;
    int seg, m, mag;
    c   = inv ? (c_in ^ 8'h55) : c_in;
    seg = int'(c[6:4]);
    m   = int'(c[3:0]);
    if (seg == 0) mag = 2 * m + 1;
    else          mag = (1 << (seg + 4)) + m * (1 << seg) + (1 << (seg - 1));
    return {c[7], 12'(mag)};
  endfunction

`ifdef PCM_EVEN_BIT_INV_EN
  localparam bit LINE_INV = 1'b1;
`else
  localparam bit LINE_INV = 1'b0;
`endif

  // Expected samples in delivery order, plus monitor state.
  logic [12:0] exp_q[$];
  int          sync_cnt   = 0;
  bit          prev_hold  = 1'b0;
  bit          prev_rst   = 1'b1;
  logic [12:0] prev_data  = '0;
  bit          rnd_ready  = 1'b0;

  // Output monitor: checks every accepted sample, hold stability under
  // back-pressure, and counts sync_err cycles.
  always @(negedge clk) begin
    if (sync_err) sync_cnt++;
    if (prev_hold && !prev_rst) begin
      chk("hold_valid", out_valid, 1);
      chk("hold_data", out_data, prev_data);
    end
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) chk("unexpected_pop_qsize", exp_q.size(), 1);
      else                   chk("sample", out_data, exp_q.pop_front());
    end
    prev_hold = out_valid && !out_ready;
    prev_rst  = rst;
    prev_data = out_data;
  end

  task automatic send_bit(input logic b, input logic fs);
    @(posedge clk);
    #2;
    bit_in     = b;
    frame_sync = fs;
    bit_valid  = 1'b1;
    if (rnd_ready) out_ready = ($urandom_range(0, 3) != 0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #2;
      bit_valid  = 1'b0;
      bit_in     = $urandom_range(0, 1);
      frame_sync = $urandom_range(0, 1);
      if (rnd_ready) out_ready = ($urandom_range(0, 3) != 0);
    end
  endtask

  // Sends one framed word; gap_pct is the chance of an idle cycle per bit.
  task automatic send_word(input logic [7:0] code, input int gap_pct);
    for (int i = 7; i >= 0; i--) begin
      while ($urandom_range(0, 99) < gap_pct) idle(1);
      send_bit(code[i], i == 7);
    end
  endtask

  task automatic wait_drain(input string tag);
    idle(1);
    rnd_ready = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 300 && exp_q.size() != 0; i++) @(posedge clk);
    idle(3);
    chk(tag, exp_q.size(), 0);
  endtask

  task automatic do_reset();
    rst        = 1'b1;
    bit_valid  = 1'b0;
    bit_in     = 1'b0;
    frame_sync = 1'b0;
    out_ready  = 1'b0;
    rnd_ready  = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b0;
    exp_q.delete();
  endtask

  initial begin
    logic [7:0]  c;
    logic [11:0] prev_mag;
    int          s0;

    do_reset();
    @(negedge clk);
    chk("rst_valid", out_valid, 0);
    chk("rst_data", out_data, 0);
    chk("rst_overrun", overrun, 0);
    chk("rst_sync_err", sync_err, 0);

    // Exhaustive expander sweep against the model, plus monotonicity.
    prev_mag = '0;
    for (int k = 0; k < 256; k++) begin
      sw_code = 8'(k);
      #1;
      chk("expand_sweep", sw_lin, lin_ref(8'(k), 1'b0));
      if (sw_code[6:0] != 7'd0) chk("monotonic", sw_lin[11:0] > prev_mag, 1);
      prev_mag = sw_lin[11:0];
    end

    // Latency: out_valid appears exactly two edges after the last bit.
    out_ready = 1'b1;
    exp_q.push_back(LINE_INV ? 13'h02B0 : 13'h0001);
    for (int i = 7; i >= 0; i--) send_bit(1'b0, i == 7);
    idle(1);
    @(negedge clk);
    chk("lat_edge1_valid", out_valid, 0);
    @(negedge clk);
    chk("lat_edge2_valid", out_valid, 1);
    chk("lat_edge2_data", out_data, LINE_INV ? 13'h02B0 : 13'h0001);
    wait_drain("lat_drain");

    // Back-to-back directed words.
`ifdef PCM_EVEN_BIT_INV_EN
    exp_q.push_back(13'h0001);
    send_word(8'h55, 0);
`else
    exp_q.push_back(13'h0021);
    exp_q.push_back(13'h00AC);
    exp_q.push_back(13'h1FC0);
    send_word(8'h10, 0);
    send_word(8'h35, 0);
    send_word(8'hFF, 0);
`endif
    wait_drain("b2b_drain");

    // Random words with random gaps and back-pressure.
    s0 = sync_cnt;
    rnd_ready = 1'b1;
    for (int k = 0; k < 40; k++) begin
      c = 8'($urandom);
      send_word(c, 20);
      exp_q.push_back(lin_ref(c, LINE_INV));
      idle($urandom_range(0, 2));
    end
    wait_drain("rand_drain");
    chk("rand_no_sync_err", sync_cnt - s0, 0);
    chk("rand_no_overrun", overrun, 0);

    // frame_sync three bits into a word.
    s0 = sync_cnt;
    send_bit(1'b1, 1'b1);
    send_bit(1'b0, 1'b0);
    send_bit(1'b1, 1'b0);
    c = 8'h6A;
    send_word(c, 0);
    exp_q.push_back(lin_ref(c, LINE_INV));
    wait_drain("sync_drain");
    chk("sync_err_cycles", sync_cnt - s0, 1);

    // Serial sweep of all codes through the DUT.
    for (int k = 0; k < 256; k++) begin
      send_word(8'(k), 0);
      exp_q.push_back(lin_ref(8'(k), LINE_INV));
    end
    wait_drain("sweep_drain");

    // Overrun: DEPTH+1 words with no consumer.
    out_ready = 1'b0;
    for (int k = 0; k <= DEPTH; k++) begin
      c = 8'($urandom);
      send_word(c, 0);
      if (k < DEPTH) exp_q.push_back(lin_ref(c, LINE_INV));
    end
    idle(3);
    @(negedge clk);
    chk("ovr_set", overrun, 1);
    chk("ovr_valid", out_valid, 1);
    idle(5);
    chk("ovr_sticky", overrun, 1);
    wait_drain("ovr_drain");
    chk("ovr_after_drain", overrun, 1);

    // Reset mid-word with two samples queued.
    out_ready = 1'b0;
    send_word(8'h21, 0);
    send_word(8'hC3, 0);
    for (int i = 7; i >= 4; i--) send_bit(1'b1, i == 7);
    @(posedge clk);
    #2;
    bit_valid = 1'b0;
    @(negedge clk);
    chk("pre_rst_valid", out_valid, 1);
    @(posedge clk);
    #2;
    rst = 1'b1;
    exp_q.delete();
    @(posedge clk);
    #2;
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_valid", out_valid, 0);
    chk("midrst_overrun", overrun, 0);
    out_ready = 1'b1;
    send_bit(1'b1, 1'b0);
    send_bit(1'b0, 1'b0);
    c = 8'hB7;
    send_word(c, 0);
    exp_q.push_back(lin_ref(c, LINE_INV));
    wait_drain("midrst_drain");

    // Full FIFO with a pop on the write cycle of the next word.
    do_reset();
    for (int k = 0; k < DEPTH; k++) begin
      c = 8'($urandom);
      send_word(c, 0);
      exp_q.push_back(lin_ref(c, LINE_INV));
    end
    c = 8'($urandom);
    send_word(c, 0);
    exp_q.push_back(lin_ref(c, LINE_INV));
    @(posedge clk);
    #2;
    bit_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #2;
    out_ready = 1'b0;
    @(negedge clk);
    chk("popw_overrun", overrun, 0);
    chk("popw_valid", out_valid, 1);
    chk("popw_qsize", exp_q.size(), DEPTH);
    wait_drain("popw_drain");
    chk("popw_overrun_end", overrun, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Absolute time bound so the bench always terminates.
  initial begin
    #2000000;
    $display("FAIL timeout: got 0x1 want 0x0");
    $fatal(1, "timeout");
  end

endmodule : tb_pcm_log2lin_rx
`default_nettype wire
